// File: rtl/load_store_unit.sv
// Load/store unit between the EX-stage ALU result and a word-indexed data memory.
// Services LB/LBU/LH/LHU/LW/SB/SH/SW. Sub-word stores run as a two-cycle
// read-modify-write that stalls the requester. Load data is returned registered.
// Optional build macro: LSU_ALIGN_CHECK_EN (flags misaligned / reserved-size accesses).
module load_store_unit #(
  parameter int unsigned MEM_WORDS  = 128,
  parameter int unsigned WORD_IDX_W = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] load_data,
  output logic        addr_error,
  output logic [31:0] mem_addr,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Index width must cover the memory exactly.
  if ((1 << WORD_IDX_W) != MEM_WORDS) begin : g_bad_cfg
    $error("load_store_unit: 2**WORD_IDX_W must equal MEM_WORDS");
  end

  typedef enum logic {
    IDLE,
    RMW_WR
  } state_t;

  state_t                state, state_nxt;
  logic [WORD_IDX_W-1:0] req_idx;
  logic [WORD_IDX_W-1:0] rmw_idx, rmw_idx_nxt;
  logic [31:0]           rmw_data, rmw_data_nxt;
  logic [31:0]           load_data_nxt;
  logic                  resp_valid_nxt;
  logic                  addr_error_nxt;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [31:0]           lane_ext;
  logic [31:0]           merged;
  logic                  is_subword;
  logic                  misaligned;
  logic                  unused_addr_hi;

  // Upper address bits wrap away: the memory only sees the low word index.
  assign req_idx        = req_addr[WORD_IDX_W+1:2];
  assign unused_addr_hi = &{1'b0, req_addr[31:WORD_IDX_W+2]};
  assign is_subword     = (req_size == SZ_BYTE) || (req_size == SZ_HALF);
  assign stall          = (state == RMW_WR);

`ifdef LSU_ALIGN_CHECK_EN
  // Halves need even addresses, words need 4-byte alignment, size 11 is illegal.
  assign misaligned = ((req_size == SZ_HALF) && req_addr[0])
                   || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                   || (req_size == SZ_RSVD);
`else
  assign misaligned = 1'b0;
`endif

  // Select the addressed byte and halfword lanes of the memory read data.
  always_comb begin
    byte_sel = mem_rdata[7:0];
    case (req_addr[1:0])
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = req_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  // Extend the selected lane to a full load result.
  always_comb begin
    lane_ext = mem_rdata;
    case (req_size)
      SZ_BYTE: lane_ext = {{24{req_signed & byte_sel[7]}}, byte_sel};
      SZ_HALF: lane_ext = {{16{req_signed & half_sel[15]}}, half_sel};
      default: lane_ext = mem_rdata;
    endcase
  end

  // Merge sub-word store data into the word just read for the RMW write-back.
  always_comb begin
    merged = mem_rdata;
    if (req_size == SZ_BYTE) begin
      case (req_addr[1:0])
        2'd0:    merged[7:0]   = req_wdata[7:0];
        2'd1:    merged[15:8]  = req_wdata[7:0];
        2'd2:    merged[23:16] = req_wdata[7:0];
        default: merged[31:24] = req_wdata[7:0];
      endcase
    end else if (req_addr[1]) begin
      merged[31:16] = req_wdata[15:0];
    end else begin
      merged[15:0] = req_wdata[15:0];
    end
  end

  // Next-state, registered-output next values and the memory interface.
  always_comb begin
    state_nxt      = state;
    rmw_idx_nxt    = rmw_idx;
    rmw_data_nxt   = rmw_data;
    resp_valid_nxt = 1'b0;
    load_data_nxt  = load_data;
    addr_error_nxt = 1'b0;
    mem_addr       = 32'(req_idx);
    mem_wdata      = req_wdata;
    mem_write      = 1'b0;

    case (state)
      IDLE: begin
        if (req_valid) begin
          if (misaligned) begin
            resp_valid_nxt = 1'b1;
            addr_error_nxt = 1'b1;
            load_data_nxt  = 32'd0;
          end else if (!req_write) begin
            resp_valid_nxt = 1'b1;
            load_data_nxt  = lane_ext;
          end else if (!is_subword) begin
            mem_write      = 1'b1;
            resp_valid_nxt = 1'b1;
            load_data_nxt  = 32'd0;
          end else begin
            rmw_idx_nxt  = req_idx;
            rmw_data_nxt = merged;
            state_nxt    = RMW_WR;
          end
        end
      end
      RMW_WR: begin
        mem_addr       = 32'(rmw_idx);
        mem_wdata      = rmw_data;
        mem_write      = 1'b1;
        resp_valid_nxt = 1'b1;
        load_data_nxt  = 32'd0;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // A reset cycle never writes memory, which also drops a pending RMW.
    if (rst) begin
      mem_write = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rmw_idx    <= '0;
      rmw_data   <= 32'd0;
      resp_valid <= 1'b0;
      load_data  <= 32'd0;
      addr_error <= 1'b0;
    end else begin
      state      <= state_nxt;
      rmw_idx    <= rmw_idx_nxt;
      rmw_data   <= rmw_data_nxt;
      resp_valid <= resp_valid_nxt;
      load_data  <= load_data_nxt;
      addr_error <= addr_error_nxt;
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the EX-stage ALU result and the word-indexed data memory.
- Converts byte addresses to word indices and services LB/LBU/LH/LHU/LW/SB/SH/SW.
- Sub-word stores are done as a two-cycle read-modify-write, stalling the requester.
- Load data is returned registered, sign- or zero-extended, to the writeback path.

Parameters:
- MEM_WORDS, 128, depth of the data memory in 32-bit words.
- WORD_IDX_W, 7, width of the word index; must satisfy 2**WORD_IDX_W == MEM_WORDS.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  access request this cycle; accepted only when stall=0.
- req_write  input  1  1=store, 0=load.
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
- req_signed  input  1  loads: 1=sign-extend, 0=zero-extend; ignored for stores.
- req_addr  input  32  byte address (ALU result).
- req_wdata  input  32  store data; byte/half taken from the low bits.
- stall  output  1  1 = request not accepted; requester holds its request.
- resp_valid  output  1  one-cycle completion pulse.
- load_data  output  32  extended load result; valid while resp_valid=1.
- addr_error  output  1  misaligned/illegal access flag, qualified by resp_valid.
- mem_addr  output  32  word index to data memory, zero-extended.
- mem_write  output  1  data memory write enable.
- mem_wdata  output  32  data memory write data.
- mem_rdata  input  32  combinational read data from data memory.

Behaviour:
- Reset: synchronous. state=IDLE; resp_valid, load_data, addr_error = 0; stall=0. mem_write is forced to 0 whenever rst=1.
- Word index: req_addr[WORD_IDX_W+1:2]. Upper address bits are ignored, so addresses wrap modulo MEM_WORDS*4.
- Byte lanes are little-endian:
  - Byte k = bits[8k+7:8k], where k = addr[1:0].
  - Halfword = bits[15:0] if addr[1]=0, else bits[31:16].
- States: IDLE, RMW_WR. stall = (state==RMW_WR). stall is registered-state only, with no combinational path from req_*.
- IDLE, accepted load (cycle N):
  - mem_addr = index.
  - mem_rdata lane is extracted and extended, then registered.
  - resp_valid=1 and load_data valid at N+1. Latency 1.
- IDLE, accepted word store (cycle N):
  - mem_addr = index, mem_wdata = req_wdata, mem_write=1 combinationally in cycle N.
  - resp_valid at N+1.
- IDLE, accepted byte/half store (cycle N):
  - mem_addr = index; mem_rdata is read.
  - Selected lane(s) are replaced by req_wdata[7:0] or [15:0]; the merged word and the index are registered.
  - Go to RMW_WR.
- RMW_WR (cycle N+1):
  - mem_addr = latched index, mem_wdata = merged word, mem_write=1, stall=1.
  - Return to IDLE; resp_valid at N+2.
- mem_write is 0 in every cycle not listed above. mem_addr/mem_wdata are don't-care when mem_write=0 and no load is active.
- resp_valid=0 for any cycle without a completing access. load_data holds its last value; it is 0 after stores.
- Back-to-back: a new request may be accepted in the same cycle resp_valid is high.
- Read-after-write: a load accepted the cycle after a word store, or after RMW_WR, sees the new data.
- Reset during RMW_WR: no write occurs, the pending store is discarded, and no resp_valid is produced.

Optional Feature:
- Macro LSU_ALIGN_CHECK_EN.
- Defined:
  - The following are errors: half with addr[0]=1; word with addr[1:0]!=0; req_size=11.
  - An erroring request is accepted with no memory write and no state change.
  - Next cycle: resp_valid=1, addr_error=1, load_data=0.
- Undefined:
  - Misaligned low address bits are ignored: half uses addr[1] only; word ignores [1:0].
  - req_size=11 is treated as word.
  - addr_error is tied 0.

Test Plan:
- Preload mem[5]=0x8899AABB. LW addr 0x14 -> at N+1: resp_valid=1, load_data=0x8899AABB, mem_write never 1.
- LB signed addr 0x17 -> load_data=0xFFFFFF88. LBU addr 0x15 -> load_data=0x000000AA.
- SB addr 0x16, wdata 0x000000CC:
  - N+1: stall=1, mem_write=1, mem_addr=5, mem_wdata=0x88CCAABB.
  - N+2: resp_valid=1.
  - Following LW 0x14 -> 0x88CCAABB.
- SH addr 0x14, wdata 0x00001234 (mem[5]=0x8899AABB) -> mem[5]=0x88991234.
  - LH signed 0x14 -> 0x00001234.
  - LH signed 0x16 -> 0xFFFF8899.
  - LHU 0x16 -> 0x00008899.
- SB addr 0x14 accepted, then rst=1 in the RMW_WR cycle -> mem_write=0, mem[5] unchanged, stall=0 and resp_valid=0 after reset.
- With LSU_ALIGN_CHECK_EN:
  - LW 0x15 -> N+1: addr_error=1, load_data=0.
  - SW 0x16 -> no write, addr_error=1.
  - Without the macro, LW 0x15 returns mem[5] and addr_error=0.
